// File: rtl/vga_pkg.sv
// Shared timing defaults and coordinate width for the 640x480 scan path.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Scan bundle between the raster sequencer and its consumers (main_logic, VGA pins).
interface vga_scan_ctrl_if;
  import vga_pkg::*;

  logic   scan_en;
  logic   pix_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   line_end;
  logic   frame_start;

  modport master (
    input  scan_en,
    output pix_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_start
  );

  modport slave (
    output scan_en,
    input  pix_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_start
  );

endinterface

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable and synchronous reset; exposes the look-ahead value
// so callers can register decodes on the same edge as the count.
module vga_mod_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);

  assign wrap = (count == W'(N - 1));

  always_comb begin
    count_nxt = count;
    if (en) count_nxt = wrap ? '0 : count + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan sequencer: pixel-rate divider, x/y scan counters and registered sync/blank decode.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/video_on one pixel behind pixel_x/pixel_y.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input logic             clk,
  input logic             rst,
  vga_scan_ctrl_if.master vga
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_scan_ctrl: CLK_DIV must be 1..16");
  end
  if (H_TOT < 1 || H_TOT > (1 << COORD_W) || V_TOT < 1 || V_TOT > (1 << COORD_W)) begin : g_bad_tot
    $error("vga_scan_ctrl: H_TOT/V_TOT must be 1..1024");
  end

  function automatic logic in_win(input coord_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

  logic [DIV_W-1:0] div_cnt_unused, div_nxt_unused;
  logic             div_wrap;
  coord_t           x, x_nxt, y, y_nxt;
  logic             x_wrap, y_wrap;
  logic             adv;

  assign adv = vga.scan_en & div_wrap;

  vga_mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
    .clk(clk), .rst(rst), .en(vga.scan_en),
    .count(div_cnt_unused), .count_nxt(div_nxt_unused), .wrap(div_wrap)
  );

  vga_mod_counter #(.N(H_TOT), .W(COORD_W)) u_x (
    .clk(clk), .rst(rst), .en(adv),
    .count(x), .count_nxt(x_nxt), .wrap(x_wrap)
  );

  vga_mod_counter #(.N(V_TOT), .W(COORD_W)) u_y (
    .clk(clk), .rst(rst), .en(adv & x_wrap),
    .count(y), .count_nxt(y_nxt), .wrap(y_wrap)
  );

  // p0: decode of the post-update coordinates, registered on the counter edge
  logic pix_tick_p0, frame_start_p0, line_end_p0;
  logic hs_p0, vs_p0, vid_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_tick_p0    <= 1'b0;
      frame_start_p0 <= 1'b0;
      line_end_p0    <= 1'b0;
      hs_p0          <= 1'b1;
      vs_p0          <= 1'b1;
      vid_p0         <= 1'b0;
    end else begin
      pix_tick_p0    <= adv;
      frame_start_p0 <= adv & x_wrap & y_wrap;
      if (adv) begin
        hs_p0       <= ~in_win(x_nxt, HS_START, HS_END);
        vs_p0       <= ~in_win(y_nxt, VS_START, VS_END);
        vid_p0      <= in_win(x_nxt, 0, H_VIS) & in_win(y_nxt, 0, V_VIS);
        line_end_p0 <= (x_nxt == COORD_W'(H_TOT - 1));
      end
    end
  end

  assign vga.pix_tick    = pix_tick_p0;
  assign vga.frame_start = frame_start_p0;
  assign vga.line_end    = line_end_p0;
  assign vga.pixel_x     = x;
  assign vga.pixel_y     = y;

`ifdef VGA_SYNC_DELAY_EN
  // p1: one pixel of extra delay so sync/blank line up with registered ROM data
  logic hs_p1, vs_p1, vid_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      vid_p1 <= 1'b0;
    end else if (adv) begin
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vid_p1 <= vid_p0;
    end
  end

  assign vga.hsync    = hs_p1;
  assign vga.vsync    = vs_p1;
  assign vga.video_on = vid_p1;
`else
  assign vga.hsync    = hs_p0;
  assign vga.vsync    = vs_p0;
  assign vga.video_on = vid_p0;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench: full 640x480 timing at CLK_DIV=2, plus a shrunken raster at CLK_DIV=1
// so that frame wrap and vsync can be reached in a short run.
module tb_vga_scan_ctrl;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vga_scan_ctrl_if vga0();
  vga_scan_ctrl_if vga1();

  vga_scan_ctrl #(.CLK_DIV(2)) u_dut (
    .clk(clk), .rst(rst0), .vga(vga0.master)
  );

  // Small raster: H_TOT=25 (hsync 18..21), V_TOT=19 (vsync 14..15), 475 pixels per frame
  vga_scan_ctrl #(
    .CLK_DIV(1), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .clk(clk), .rst(rst1), .vga(vga1.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_tick0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (vga0.pix_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_xy0(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      step();
      if (vga0.pix_tick === 1'b1 && int'(vga0.pixel_x) == x && int'(vga0.pixel_y) == y) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [25:0] got;
    rst0 = 1'b1;
    vga0.scan_en = 1'b1;
    step();
    step();
    got = {vga0.pix_tick, vga0.pixel_x, vga0.pixel_y, vga0.hsync, vga0.vsync,
           vga0.video_on, vga0.line_end, vga0.frame_start};
    vectors++;
    if (got !== {1'b0, 10'd0, 10'd0, 5'b11000}) begin
      miscompares++;
      $display("FAIL reset_state: got %b required %b", got, {1'b0, 10'd0, 10'd0, 5'b11000});
    end
    rst0 = 1'b0;
    step();
    vectors++;
    if (vga0.pix_tick !== 1'b0 || vga0.pixel_x !== 10'd0 || vga0.video_on !== 1'b0) begin
      miscompares++;
      $display("FAIL first_clk: pix_tick=%b x=%0d video_on=%b, required 0/0/0",
               vga0.pix_tick, vga0.pixel_x, vga0.video_on);
    end
    step();
    vectors++;
    if (vga0.pix_tick !== 1'b1 || vga0.pixel_x !== 10'd1 || vga0.pixel_y !== 10'd0 ||
        vga0.hsync !== 1'b1 || vga0.vsync !== 1'b1 || vga0.video_on !== 1'b1) begin
      miscompares++;
      $display("FAIL first_tick: tick=%b x=%0d y=%0d hs=%b vs=%b vid=%b, required 1/1/0/1/1/1",
               vga0.pix_tick, vga0.pixel_x, vga0.pixel_y, vga0.hsync, vga0.vsync, vga0.video_on);
    end
    step();
    vectors++;
    if (vga0.pix_tick !== 1'b0 || vga0.pixel_x !== 10'd1) begin
      miscompares++;
      $display("FAIL tick_gap: tick=%b x=%0d, required 0/1", vga0.pix_tick, vga0.pixel_x);
    end
    step();
    vectors++;
    if (vga0.pix_tick !== 1'b1 || vga0.pixel_x !== 10'd2) begin
      miscompares++;
      $display("FAIL second_tick: tick=%b x=%0d, required 1/2", vga0.pix_tick, vga0.pixel_x);
    end
  endtask

  task automatic test_line_end();
    bit ok;
    wait_xy0(639, 0, ok);
    vectors++;
    if (!ok || vga0.video_on !== 1'b1 || vga0.line_end !== 1'b0) begin
      miscompares++;
      $display("FAIL at_639: reached=%0b vid=%b le=%b, required 1/1/0", ok, vga0.video_on, vga0.line_end);
    end
    for (int i = 640; i < 800; i++) begin
      next_tick0(ok);
      vectors++;
      if (!ok || int'(vga0.pixel_x) != i || vga0.pixel_y !== 10'd0 || vga0.video_on !== 1'b0 ||
          vga0.line_end !== (i == 799)) begin
        miscompares++;
        $display("FAIL blank_x%0d: tick=%0b x=%0d y=%0d vid=%b le=%b, required x=%0d vid=0 le=%0b",
                 i, ok, vga0.pixel_x, vga0.pixel_y, vga0.video_on, vga0.line_end, i, (i == 799));
      end
    end
    next_tick0(ok);
    vectors++;
    if (!ok || vga0.pixel_x !== 10'd0 || vga0.pixel_y !== 10'd1 || vga0.line_end !== 1'b0 ||
        vga0.video_on !== 1'b1) begin
      miscompares++;
      $display("FAIL line_wrap: x=%0d y=%0d le=%b vid=%b, required 0/1/0/1",
               vga0.pixel_x, vga0.pixel_y, vga0.line_end, vga0.video_on);
    end
  endtask

  task automatic test_hsync();
    bit ok;
    int lows = 0;
    logic exp_hs;
    wait_xy0(0, 5, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_0_5: x=%0d y=%0d, required 0/5", vga0.pixel_x, vga0.pixel_y);
    end
    for (int i = 0; i < 800; i++) begin
      exp_hs = !(i >= 656 && i <= 751);
      vectors++;
      if (int'(vga0.pixel_x) != i || vga0.pixel_y !== 10'd5 || vga0.hsync !== exp_hs) begin
        miscompares++;
        $display("FAIL hsync_x%0d: x=%0d y=%0d hs=%b, required x=%0d y=5 hs=%b",
                 i, vga0.pixel_x, vga0.pixel_y, vga0.hsync, i, exp_hs);
      end
      if (vga0.hsync === 1'b0) lows++;
      next_tick0(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL hsync_tick%0d: no pix_tick within budget, required one", i);
      end
    end
    vectors++;
    if (lows != 96 || vga0.pixel_x !== 10'd0 || vga0.pixel_y !== 10'd6) begin
      miscompares++;
      $display("FAIL hsync_width: lows=%0d end x=%0d y=%0d, required 96 at 0/6",
               lows, vga0.pixel_x, vga0.pixel_y);
    end
  endtask

  task automatic test_pause();
    bit ok;
    wait_xy0(300, 6, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_300_6: x=%0d y=%0d, required 300/6", vga0.pixel_x, vga0.pixel_y);
    end
    vga0.scan_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      vectors++;
      if (vga0.pix_tick !== 1'b0 || vga0.pixel_x !== 10'd300 || vga0.pixel_y !== 10'd6 ||
          vga0.video_on !== 1'b1 || vga0.frame_start !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_clk%0d: tick=%b x=%0d y=%0d vid=%b fs=%b, required 0/300/6/1/0",
                 i, vga0.pix_tick, vga0.pixel_x, vga0.pixel_y, vga0.video_on, vga0.frame_start);
      end
    end
    vga0.scan_en = 1'b1;
    step();
    vectors++;
    if (vga0.pix_tick !== 1'b0 || vga0.pixel_x !== 10'd300) begin
      miscompares++;
      $display("FAIL resume_clk0: tick=%b x=%0d, required 0/300", vga0.pix_tick, vga0.pixel_x);
    end
    step();
    vectors++;
    if (vga0.pix_tick !== 1'b1 || vga0.pixel_x !== 10'd301 || vga0.pixel_y !== 10'd6) begin
      miscompares++;
      $display("FAIL resume_tick: tick=%b x=%0d y=%0d, required 1/301/6",
               vga0.pix_tick, vga0.pixel_x, vga0.pixel_y);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [25:0] got;
    wait_xy0(400, 6, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_400_6: x=%0d y=%0d, required 400/6", vga0.pixel_x, vga0.pixel_y);
    end
    rst0 = 1'b1;
    step();
    got = {vga0.pix_tick, vga0.pixel_x, vga0.pixel_y, vga0.hsync, vga0.vsync,
           vga0.video_on, vga0.line_end, vga0.frame_start};
    vectors++;
    if (got !== {1'b0, 10'd0, 10'd0, 5'b11000}) begin
      miscompares++;
      $display("FAIL midreset_state: got %b required %b", got, {1'b0, 10'd0, 10'd0, 5'b11000});
    end
    rst0 = 1'b0;
    step();
    step();
    vectors++;
    if (vga0.pix_tick !== 1'b1 || vga0.pixel_x !== 10'd1 || vga0.pixel_y !== 10'd0 ||
        vga0.frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_restart: tick=%b x=%0d y=%0d fs=%b, required 1/1/0/0",
               vga0.pix_tick, vga0.pixel_x, vga0.pixel_y, vga0.frame_start);
    end
  endtask

  task automatic test_small_frame();
    logic [25:0] got, req;
    int ex = 0, ey = 0, frames = 0, vs_low = 0;
    logic fs;
    rst1 = 1'b1;
    vga1.scan_en = 1'b1;
    step();
    got = {vga1.pix_tick, vga1.pixel_x, vga1.pixel_y, vga1.hsync, vga1.vsync,
           vga1.video_on, vga1.line_end, vga1.frame_start};
    vectors++;
    if (got !== {1'b0, 10'd0, 10'd0, 5'b11000}) begin
      miscompares++;
      $display("FAIL small_reset: got %b required %b", got, {1'b0, 10'd0, 10'd0, 5'b11000});
    end
    rst1 = 1'b0;
    for (int k = 1; k <= 950; k++) begin
      step();
      fs = (ex == 24 && ey == 18);
      if (ex == 24) begin
        ex = 0;
        ey = (ey == 18) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      req = {1'b1, 10'(ex), 10'(ey), !(ex >= 18 && ex <= 21), !(ey >= 14 && ey <= 15),
             (ex < 16 && ey < 12), (ex == 24), fs};
      got = {vga1.pix_tick, vga1.pixel_x, vga1.pixel_y, vga1.hsync, vga1.vsync,
             vga1.video_on, vga1.line_end, vga1.frame_start};
      vectors++;
      if (got !== req) begin
        miscompares++;
        $display("FAIL small_clk%0d: got %b required %b", k, got, req);
      end
      if (vga1.frame_start === 1'b1) frames++;
      if (vga1.vsync === 1'b0) vs_low++;
    end
    vectors++;
    if (frames != 2 || vs_low != 100) begin
      miscompares++;
      $display("FAIL small_totals: frame_starts=%0d vsync_low=%0d, required 2/100", frames, vs_low);
    end
    vga1.scan_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (vga1.pix_tick !== 1'b0 || vga1.frame_start !== 1'b0 || vga1.pixel_x !== 10'd0 ||
          vga1.pixel_y !== 10'd0) begin
        miscompares++;
        $display("FAIL small_pause%0d: tick=%b fs=%b x=%0d y=%0d, required 0/0/0/0",
                 i, vga1.pix_tick, vga1.frame_start, vga1.pixel_x, vga1.pixel_y);
      end
    end
    vga1.scan_en = 1'b1;
    for (int i = 0; i < 60; i++) step();
    rst1 = 1'b1;
    step();
    got = {vga1.pix_tick, vga1.pixel_x, vga1.pixel_y, vga1.hsync, vga1.vsync,
           vga1.video_on, vga1.line_end, vga1.frame_start};
    vectors++;
    if (got !== {1'b0, 10'd0, 10'd0, 5'b11000}) begin
      miscompares++;
      $display("FAIL small_midreset: got %b required %b", got, {1'b0, 10'd0, 10'd0, 5'b11000});
    end
    rst1 = 1'b0;
    step();
    vectors++;
    if (vga1.pix_tick !== 1'b1 || vga1.pixel_x !== 10'd1 || vga1.pixel_y !== 10'd0 ||
        vga1.frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL small_restart: tick=%b x=%0d y=%0d fs=%b, required 1/1/0/0",
               vga1.pix_tick, vga1.pixel_x, vga1.pixel_y, vga1.frame_start);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    vga0.scan_en = 1'b0;
    vga1.scan_en = 1'b0;
    test_reset();
    test_line_end();
    test_hsync();
    test_pause();
    test_reset_mid();
    test_small_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Raster scan sequencer for the 640x480 display path.
- Generates the pixel-rate enable and the horizontal/vertical counters that drive pixel_x/pixel_y into main_logic.
- Generates hsync/vsync/video_on for the VGA connector, plus line/frame strobes for the frame-level logic.
- Sits between the board clock and main_logic; it is the only source of scan coordinates in the design.

Parameters:
- CLK_DIV, 2, system clocks per pixel (legal 1..16); 50 MHz / 2 = 25 MHz pixel rate.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_VIS, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- scan_en  in  1  1 = scanning runs; 0 = counters freeze, pix_tick held 0.
- pix_tick  out  1  one-clk pulse; the counters advance on this cycle.
- pixel_x  out  10  horizontal count, 0..H_TOT-1 (H_TOT = 800).
- pixel_y  out  10  vertical count, 0..V_TOT-1 (V_TOT = 525).
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- video_on  out  1  1 when pixel_x < H_VIS and pixel_y < V_VIS.
- line_end  out  1  one-pix_tick pulse while pixel_x == H_TOT-1.
- frame_start  out  1  one-clk pulse on the pix_tick that wraps the counters to (0,0).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high; it has priority over scan_en.
- Reset values:
  - div counter = 0, pixel_x = 0, pixel_y = 0.
  - pix_tick = 0, hsync = 1, vsync = 1, video_on = 0, line_end = 0, frame_start = 0.
- Divider:
  - div counts 0..CLK_DIV-1 while scan_en = 1.
  - pix_tick is asserted for exactly the clk in which div == CLK_DIV-1; div then wraps to 0.
  - With CLK_DIV = 1, pix_tick = scan_en every clk.
  - First pix_tick occurs CLK_DIV clks after rst deasserts.
- Counters:
  - On a pix_tick clk edge, pixel_x increments.
  - At H_TOT-1, pixel_x wraps to 0 and pixel_y increments.
  - At (H_TOT-1, V_TOT-1), both wrap to 0.
  - Counter updates and output updates occur on the same edge, so all outputs are registered and mutually aligned.
- Decode, from the new (post-update) counter values:
  - hsync = 0 iff H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC, i.e. 490..491.
  - video_on = 1 iff x < 640 and y < 480.
  - line_end = 1 iff x == 799.
- frame_start: high for one clk following the edge on which (799,524) wraps to (0,0). It is not asserted out of reset.
- scan_en = 0:
  - div, pixel_x and pixel_y hold their values.
  - Decoded outputs hold; pix_tick and frame_start are 0.
  - Resuming continues from the held div value.
- Reset mid-frame: next clk all state returns to the reset values. The next frame starts at (0,0) with no frame_start.
- Width rules:
  - H_TOT and V_TOT are the sums of their four parameters and must each be <= 1024.
  - Out-of-range parameters are a compile-time error.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- With VGA_SYNC_DELAY_EN defined:
  - hsync, vsync and video_on gain one extra pix_tick-qualified register stage.
  - This aligns them with ROM data returned one pixel after rom_address.
  - pixel_x/pixel_y are not delayed.
  - The delay stage resets to hsync = 1, vsync = 1, video_on = 0.
- Without VGA_SYNC_DELAY_EN: timing is exactly as specified in Behaviour.

Decomposition:
- Package vga_pkg holds:
  - default timing constants (H_VIS..V_BP);
  - derived H_TOT/V_TOT;
  - sync start/end constants;
  - the coordinate width constant COORD_W = 10.
- Sub-module vga_mod_counter: parameterised modulo-N counter with enable, synchronous rst and a wrap output. It is instantiated for the divider, for x, and for y (y enabled by the x wrap qualified with pix_tick).

Test Plan:
- Reset then release, CLK_DIV = 2, scan_en = 1 -> first pix_tick at clk 2, then every 2nd clk; pixel_x reads 1 after the first tick; hsync = 1, vsync = 1.
- Run to x = 799, y = 0 -> line_end = 1; next tick gives x = 0, y = 1, line_end = 0; video_on = 0 for x in 640..799.
- Scan line y = 5 -> hsync = 0 for exactly x = 656..751 (96 ticks), otherwise 1.
- Run a full frame -> vsync = 0 only for y = 490..491; at (799,524) the next tick gives (0,0) and a single-clk frame_start; 800*525 = 420000 ticks per frame.
- At (300,200), deassert scan_en for 7 clks -> no pix_tick, counters hold; on resume the next tick gives (301,200).
- At (400,300), assert rst for 1 clk -> all outputs return to reset values and no frame_start. Repeat with CLK_DIV = 1 -> pix_tick every clk.
